aes_key_sched_rev: RTL and testbench

Iterative reverse-order AES-128 key scheduler for the decryption datapath. It accepts either the cipher key or the final (round 10) key and delivers round keys 10, 9, … 0, one per handshake, through a valid/ready stream. Where the cipher key is supplied, it first runs the schedule forward to reach round 10. It reuses the existing `aes_sbox` and computes one schedule step per cycle, so it needs only 4 S-boxes instead of the 40 used by full combinational expansion.

---
 rtl/aes_pkg.sv | 33 +++
 rtl/aes_key_step.sv | 43 ++++
 rtl/aes_sbox.sv | 39 +++
 rtl/aes_key_sched_rev.sv | 150 +++++++++++++++
 tb/tb_aes_key_sched_rev.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key schedule.
// Holds the round count, rcon lookup, FSM state enum and round-key type.
package aes_pkg;

  localparam int AES_NROUNDS = 10;

  typedef logic [127:0] rk_t;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    EMIT
  } ks_state_e;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step, forward (rev=0) or reverse (rev=1).
// Both directions share the same four S-boxes.
module aes_key_step
  import aes_pkg::*;
(
  input  rk_t        key,
  input  logic [7:0] rcon_byte,
  input  logic       rev,
  output rk_t        next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] r1, r2, r3;
  logic [31:0] sb_in, rot, sub, t;
  logic [31:0] f0, f1, f2, f3;

  assign {w0, w1, w2, w3} = key;

  assign r3 = w3 ^ w2;
  assign r2 = w2 ^ w1;
  assign r1 = w1 ^ w0;

  assign sb_in = rev ? r3 : w3;
  assign rot   = {sb_in[23:0], sb_in[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (rot[8*i +: 8]),
      .dout (sub[8*i +: 8])
    );
  end

  assign t = sub ^ {rcon_byte, 24'h0};

  assign f0 = w0 ^ t;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  assign next_key = rev ? {w0 ^ t, r1, r2, r3}
                        : {f0, f1, f2, f3};

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: GF(2^8) inverse (x^254) followed by the affine map.
// Purely combinational.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    // x^254 = x^(2+4+...+128); zero maps to zero
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  assign dout = sbox(din);

endmodule

// File: rtl/aes_key_sched_rev.sv
// Iterative reverse-order AES-128 key scheduler (round 10 down to 0).
// Define AES_KEY_CACHE_EN to keep the round-10 key for replay.
module aes_key_sched_rev
  import aes_pkg::*;
#(
  parameter int NROUNDS = AES_NROUNDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_is_last,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         replay,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         rk_last,
  output logic         busy
);

  localparam logic [3:0] LAST    = 4'(NROUNDS);
  localparam logic [3:0] LAST_M1 = LAST - 4'd1;

  ks_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  rk_t        key_q, key_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;

  rk_t        step_key;
  logic       step_rev;
  logic [3:0] rcon_idx;

  assign step_rev = (state_q == EMIT);
  assign rcon_idx = step_rev ? cnt_q - 4'd1 : cnt_q;

  aes_key_step u_step (
    .key       (key_q),
    .rcon_byte (rcon(rcon_idx)),
    .rev       (step_rev),
    .next_key  (step_key)
  );

`ifdef AES_KEY_CACHE_EN
  rk_t  cache_q;
  logic cache_vld_q;
`else
  logic unused_replay;
  assign unused_replay = replay;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    valid_d = valid_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          key_d = key_in;
          if (key_is_last) begin
            state_d = EMIT;
            cnt_d   = LAST;
            valid_d = 1'b1;
            last_d  = 1'b0;
          end else begin
            state_d = FWD;
            cnt_d   = 4'd0;
          end
        end
`ifdef AES_KEY_CACHE_EN
        else if (replay && cache_vld_q) begin
          key_d   = cache_q;
          state_d = EMIT;
          cnt_d   = LAST;
          valid_d = 1'b1;
          last_d  = 1'b0;
        end
`endif
      end
      FWD: begin
        key_d = step_key;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_M1) begin
          state_d = EMIT;
          valid_d = 1'b1;
          last_d  = 1'b0;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (cnt_q == 4'd0) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            key_d  = step_key;
            cnt_d  = cnt_q - 4'd1;
            last_d = (cnt_q == 4'd1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      key_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

`ifdef AES_KEY_CACHE_EN
  // Capture whatever key enters EMIT; it is always round 10
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_q     <= '0;
      cache_vld_q <= 1'b0;
    end else if (state_d == EMIT && state_q != EMIT) begin
      cache_q     <= key_d;
      cache_vld_q <= 1'b1;
    end
  end
`endif

  assign rk_out    = key_q;
  assign rk_round  = cnt_q;
  assign rk_valid  = valid_q;
  assign rk_last   = last_q;
  assign key_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_key_sched_rev.sv
// Directed bench for aes_key_sched_rev using the FIPS-197 example key.
// Inputs change and outputs are sampled on the falling edge.
module tb_aes_key_sched_rev;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_is_last;
  logic         key_valid;
  logic         key_ready;
  logic         replay;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         rk_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_rk [0:10];

  always #5 clk = ~clk;

  aes_key_sched_rev dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .key_is_last (key_is_last),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .replay      (replay),
    .rk_out      (rk_out),
    .rk_round    (rk_round),
    .rk_valid    (rk_valid),
    .rk_ready    (rk_ready),
    .rk_last     (rk_last),
    .busy        (busy)
  );

  task automatic load(input logic [127:0] k, input logic last);
    @(negedge clk);
    key_in      = k;
    key_is_last = last;
    key_valid   = 1'b1;
    @(negedge clk);
    key_valid   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rk_out !== '0 || rk_round !== 4'd0 || rk_valid !== 1'b0 ||
        rk_last !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: out=%h rnd=%0d v=%b l=%b busy=%b rdy=%b exp 0/0/0/0/0/1",
               rk_out, rk_round, rk_valid, rk_last, busy, key_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: v=%b rdy=%b exp 0/1", rk_valid, key_ready);
    end
  endtask

  task automatic test_cipher_load;
    rk_ready = 1'b1;
    load(exp_rk[0], 1'b0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rk_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL fwd_latency: cyc T+%0d v=%b busy=%b exp 0/1", i + 1, rk_valid, busy);
      end
      @(negedge clk);
    end
    for (int r = 10; r >= 0; r--) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== exp_rk[r] ||
          rk_last !== (r == 0)) begin
        errors++;
        $display("FAIL cipher_seq r%0d: v=%b rnd=%0d l=%b out=%h exp %h",
                 r, rk_valid, rk_round, rk_last, rk_out, exp_rk[r]);
      end
      @(negedge clk);
    end
    checks++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cipher_end: v=%b rdy=%b busy=%b exp 0/1/0", rk_valid, key_ready, busy);
    end
  endtask

  task automatic test_last_load;
    rk_ready = 1'b1;
    load(exp_rk[10], 1'b1);
    for (int r = 10; r >= 0; r--) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== exp_rk[r] ||
          rk_last !== (r == 0)) begin
        errors++;
        $display("FAIL last_seq r%0d: v=%b rnd=%0d l=%b out=%h exp %h",
                 r, rk_valid, rk_round, rk_last, rk_out, exp_rk[r]);
      end
      @(negedge clk);
    end
    checks++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL last_end: v=%b rdy=%b exp 0/1", rk_valid, key_ready);
    end
  endtask

  task automatic test_backpressure;
    int           r = 10;
    bit           done = 1'b0;
    bit           stall = 1'b0;
    logic [127:0] s_out;
    logic [3:0]   s_rnd;
    logic         s_last;
    rk_ready = 1'b0;
    load(exp_rk[0], 1'b0);
    repeat (10) @(negedge clk);
    for (int c = 0; c < 400 && !done; c++) begin
      if (stall) begin
        checks++;
        if (rk_out !== s_out || rk_round !== s_rnd || rk_last !== s_last) begin
          errors++;
          $display("FAIL bp_stable: rnd=%0d out=%h exp rnd=%0d out=%h",
                   rk_round, rk_out, s_rnd, s_out);
        end
      end
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== exp_rk[r] ||
          rk_last !== (r == 0)) begin
        errors++;
        $display("FAIL bp_seq r%0d: v=%b rnd=%0d out=%h exp %h",
                 r, rk_valid, rk_round, rk_out, exp_rk[r]);
      end
      rk_ready = 1'($urandom_range(0, 1));
      stall    = !rk_ready;
      s_out    = rk_out;
      s_rnd    = rk_round;
      s_last   = rk_last;
      if (rk_ready) begin
        if (r == 0) done = 1'b1;
        else r--;
      end
      @(negedge clk);
    end
    checks++;
    if (!done || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_timeout: done=%b v=%b exp 1/0", done, rk_valid);
    end
  endtask

  task automatic test_load_during_emit;
    rk_ready = 1'b0;
    load(exp_rk[10], 1'b1);
    key_in      = exp_rk[3];
    key_is_last = 1'b1;
    key_valid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (key_ready !== 1'b0 || rk_round !== 4'd10 || rk_out !== exp_rk[10]) begin
        errors++;
        $display("FAIL busy_load: rdy=%b rnd=%0d out=%h exp 0/10/%h",
                 key_ready, rk_round, rk_out, exp_rk[10]);
      end
      @(negedge clk);
    end
    rk_ready = 1'b1;
    for (int r = 10; r >= 0; r--) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== exp_rk[r]) begin
        errors++;
        $display("FAIL busy_seq r%0d: v=%b rnd=%0d out=%h exp %h",
                 r, rk_valid, rk_round, rk_out, exp_rk[r]);
      end
      if (r == 1) key_valid = 1'b0;
      @(negedge clk);
    end
    key_valid = 1'b0;
    checks++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_end: v=%b rdy=%b exp 0/1", rk_valid, key_ready);
    end
  endtask

  task automatic test_reset_mid_fwd;
    rk_ready = 1'b1;
    load(exp_rk[0], 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset: busy=%b v=%b exp 1/0", busy, rk_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rk_out !== '0 || rk_round !== 4'd0 || rk_valid !== 1'b0 ||
        rk_last !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: out=%h rnd=%0d v=%b l=%b busy=%b rdy=%b exp 0/0/0/0/0/1",
               rk_out, rk_round, rk_valid, rk_last, busy, key_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load(exp_rk[0], 1'b0);
    repeat (10) @(negedge clk);
    for (int r = 10; r >= 0; r--) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== exp_rk[r]) begin
        errors++;
        $display("FAIL post_reset_seq r%0d: v=%b rnd=%0d out=%h exp %h",
                 r, rk_valid, rk_round, rk_out, exp_rk[r]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_replay;
    rk_ready = 1'b1;
    @(negedge clk);
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
`ifdef AES_KEY_CACHE_EN
    for (int r = 10; r >= 0; r--) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== exp_rk[r]) begin
        errors++;
        $display("FAIL replay_seq r%0d: v=%b rnd=%0d out=%h exp %h",
                 r, rk_valid, rk_round, rk_out, exp_rk[r]);
      end
      @(negedge clk);
    end
    checks++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL replay_end: v=%b rdy=%b exp 0/1", rk_valid, key_ready);
    end
`else
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rk_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL replay_ignored: v=%b busy=%b exp 0/0", rk_valid, busy);
      end
      @(negedge clk);
    end
`endif
  endtask

  initial begin
    exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    key_in      = '0;
    key_is_last = 1'b0;
    key_valid   = 1'b0;
    replay      = 1'b0;
    rk_ready    = 1'b0;
    test_reset();
    test_cipher_load();
    test_last_load();
    test_backpressure();
    test_load_during_emit();
    test_reset_mid_fwd();
    test_replay();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
